// File: rtl/clock_ctrl_pkg.sv
// Shared encodings for the clock mode controller: modes, edit fields, beep length default.
// Mode sequencing depends on CLOCK_MODE_CTRL_STOPWATCH_EN (stopwatch mode present when defined).
package clock_ctrl_pkg;

    localparam logic [1:0] MODE_CLOCK     = 2'd0;
    localparam logic [1:0] MODE_SET       = 2'd1;
    localparam logic [1:0] MODE_ALARM     = 2'd2;
    localparam logic [1:0] MODE_STOPWATCH = 2'd3;

    typedef enum logic [1:0] {
        FIELD_SEC  = 2'd0,
        FIELD_MIN  = 2'd1,
        FIELD_HOUR = 2'd2
    } field_e;

    localparam int BEEP_LEN_DEFAULT = 8;

    function automatic logic [1:0] next_mode(input logic [1:0] mode);
`ifdef CLOCK_MODE_CTRL_STOPWATCH_EN
        next_mode = mode + 2'd1;
`else
        next_mode = (mode == MODE_ALARM) ? MODE_CLOCK : mode + 2'd1;
`endif
    endfunction

endpackage

// File: rtl/clock_mode_ctrl_sw_edge.sv
// Switch sampler: registers the previous level and flags the cycle where the input rises.
module sw_edge (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sw_i,
    output logic press_o
);

    logic prev_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= sw_i;
        end
    end

    assign press_o = sw_i & ~prev_q;

endmodule

// File: rtl/clock_mode_ctrl.sv
// Mode/field controller for a digital clock with alarm beeper and optional stopwatch.
// Stopwatch mode is built only when CLOCK_MODE_CTRL_STOPWATCH_EN is defined.
module clock_mode_ctrl
    import clock_ctrl_pkg::*;
#(
    parameter int BEEP_LEN = BEEP_LEN_DEFAULT
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       SW_MODE,
    input  logic       SW_F1,
    input  logic       SW_F2,
    input  logic       ALM_MATCH,
    output logic [1:0] MODE,
    output logic [1:0] FIELD,
    output logic [2:0] INC_TIME,
    output logic [1:0] INC_ALM,
    output logic       ALM_EN,
    output logic       SW_RUN,
    output logic       SW_CLR,
    output logic       BEEP
);

    logic press_mode, press_f1, press_f2, any_press, consume;

    sw_edge u_edge_mode (.clk_i(CLK), .rst_ni(RST_N), .sw_i(SW_MODE), .press_o(press_mode));
    sw_edge u_edge_f1   (.clk_i(CLK), .rst_ni(RST_N), .sw_i(SW_F1),   .press_o(press_f1));
    sw_edge u_edge_f2   (.clk_i(CLK), .rst_ni(RST_N), .sw_i(SW_F2),   .press_o(press_f2));

    assign any_press = press_mode | press_f1 | press_f2;
    // A press during a beep only silences it.
    assign consume   = BEEP & any_press;

    logic [1:0] mode_q, mode_d;
    logic [1:0] field_q, field_d;
    logic [2:0] inc_time_q, inc_time_d;
    logic [1:0] inc_alm_q, inc_alm_d;
    logic       alm_en_q, alm_en_d;
    logic       beep_q, beep_d;
    logic [7:0] beep_cnt_q, beep_cnt_d;

    always_comb begin
        mode_d     = mode_q;
        field_d    = field_q;
        inc_time_d = '0;
        inc_alm_d  = '0;
        alm_en_d   = alm_en_q;
        beep_d     = beep_q;
        beep_cnt_d = beep_cnt_q;
        if (consume) begin
            beep_d     = 1'b0;
            beep_cnt_d = '0;
        end else begin
            if (press_mode) begin
                mode_d = next_mode(mode_q);
                if (mode_d == MODE_SET) begin
                    field_d = FIELD_SEC;
                end else if (mode_d == MODE_ALARM) begin
                    field_d = FIELD_MIN;
                end
            end else if (press_f1) begin
                case (mode_q)
                    MODE_CLOCK: alm_en_d = ~alm_en_q;
                    MODE_SET:   field_d  = (field_q == FIELD_HOUR) ? FIELD_SEC : field_q + 2'd1;
                    MODE_ALARM: field_d  = (field_q == FIELD_MIN) ? FIELD_HOUR : FIELD_MIN;
                    default:    ;
                endcase
            end else if (press_f2) begin
                case (mode_q)
                    MODE_SET:   inc_time_d = 3'b001 << field_q;
                    MODE_ALARM: inc_alm_d  = (field_q == FIELD_HOUR) ? 2'b10 : 2'b01;
                    default:    ;
                endcase
            end
            // beep_cnt_q holds the cycles left after the current one
            if (beep_q) begin
                if (!alm_en_q || beep_cnt_q == 8'd0) begin
                    beep_d     = 1'b0;
                    beep_cnt_d = '0;
                end else begin
                    beep_cnt_d = beep_cnt_q - 8'd1;
                end
            end else if (ALM_MATCH && alm_en_q) begin
                beep_d     = 1'b1;
                beep_cnt_d = 8'(BEEP_LEN - 1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            mode_q     <= MODE_CLOCK;
            field_q    <= FIELD_SEC;
            inc_time_q <= '0;
            inc_alm_q  <= '0;
            alm_en_q   <= 1'b0;
            beep_q     <= 1'b0;
            beep_cnt_q <= '0;
        end else begin
            mode_q     <= mode_d;
            field_q    <= field_d;
            inc_time_q <= inc_time_d;
            inc_alm_q  <= inc_alm_d;
            alm_en_q   <= alm_en_d;
            beep_q     <= beep_d;
            beep_cnt_q <= beep_cnt_d;
        end
    end

`ifdef CLOCK_MODE_CTRL_STOPWATCH_EN
    logic sw_run_q, sw_run_d, sw_clr_q, sw_clr_d;

    // Run state lives outside the mode register so it survives mode changes.
    always_comb begin
        sw_run_d = sw_run_q;
        sw_clr_d = 1'b0;
        if (!consume && !press_mode && mode_q == MODE_STOPWATCH) begin
            if (press_f1) begin
                sw_run_d = ~sw_run_q;
            end else if (press_f2) begin
                sw_clr_d = ~sw_run_q;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            sw_run_q <= 1'b0;
            sw_clr_q <= 1'b0;
        end else begin
            sw_run_q <= sw_run_d;
            sw_clr_q <= sw_clr_d;
        end
    end

    assign SW_RUN = sw_run_q;
    assign SW_CLR = sw_clr_q;
`else
    assign SW_RUN = 1'b0;
    assign SW_CLR = 1'b0;
`endif

    assign MODE     = mode_q;
    assign FIELD    = field_q;
    assign INC_TIME = inc_time_q;
    assign INC_ALM  = inc_alm_q;
    assign ALM_EN   = alm_en_q;
    assign BEEP     = beep_q;

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Self-checking bench for clock_mode_ctrl: vector table, directed corner sequences,
// and randomized traffic compared against a behavioural model.
module tb_clock_mode_ctrl;

    localparam int BL = 8;
`ifdef CLOCK_MODE_CTRL_STOPWATCH_EN
    localparam int NMODES = 4;
`else
    localparam int NMODES = 3;
`endif

    logic CLK = 1'b0, RST_N = 1'b0, SW_MODE = 1'b0, SW_F1 = 1'b0, SW_F2 = 1'b0, ALM_MATCH = 1'b0;
    logic [1:0] MODE, FIELD, INC_ALM;
    logic [2:0] INC_TIME;
    logic       ALM_EN, SW_RUN, SW_CLR, BEEP;

    clock_mode_ctrl #(.BEEP_LEN(BL)) dut (
        .CLK(CLK), .RST_N(RST_N), .SW_MODE(SW_MODE), .SW_F1(SW_F1), .SW_F2(SW_F2),
        .ALM_MATCH(ALM_MATCH), .MODE(MODE), .FIELD(FIELD), .INC_TIME(INC_TIME),
        .INC_ALM(INC_ALM), .ALM_EN(ALM_EN), .SW_RUN(SW_RUN), .SW_CLR(SW_CLR), .BEEP(BEEP)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state, kept as plain integers and counters.
    int       m_mode, m_field, m_beep_left;
    bit       m_alm_en, m_run, m_clr;
    bit [2:0] m_inc_time;
    bit [1:0] m_inc_alm;
    bit [2:0] m_prev;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit [2:0] cur, pr;
        bit old_en, old_beep;
        m_inc_time = '0;
        m_inc_alm  = '0;
        m_clr      = 1'b0;
        if (!RST_N) begin
            m_mode = 0; m_field = 0; m_alm_en = 0; m_run = 0; m_beep_left = 0; m_prev = '0;
            return;
        end
        cur      = {SW_MODE, SW_F1, SW_F2};
        pr       = cur & ~m_prev;
        m_prev   = cur;
        old_en   = m_alm_en;
        old_beep = (m_beep_left > 0);
        if (old_beep && pr != 3'b000) begin
            m_beep_left = 0;
        end else begin
            if (pr[2]) begin
                m_mode = (m_mode + 1) % NMODES;
                if (m_mode == 1) m_field = 0;
                else if (m_mode == 2) m_field = 1;
            end else if (pr[1]) begin
                case (m_mode)
                    0: m_alm_en = !m_alm_en;
                    1: m_field = (m_field + 1) % 3;
                    2: m_field = (m_field == 1) ? 2 : 1;
                    default: m_run = !m_run;
                endcase
            end else if (pr[0]) begin
                case (m_mode)
                    1: m_inc_time = 3'(1 << m_field);
                    2: m_inc_alm = (m_field == 2) ? 2'b10 : 2'b01;
                    3: m_clr = !m_run;
                    default: ;
                endcase
            end
            if (old_beep) m_beep_left = old_en ? m_beep_left - 1 : 0;
            else if (ALM_MATCH && old_en) m_beep_left = BL;
        end
    endtask

    task automatic cyc(input bit r, input bit m, input bit f1, input bit f2, input bit am);
        RST_N = r; SW_MODE = m; SW_F1 = f1; SW_F2 = f2; ALM_MATCH = am;
        model_edge();
        @(posedge CLK);
        #1;
        chk("model_MODE", int'(MODE), m_mode);
        chk("model_FIELD", int'(FIELD), m_field);
        chk("model_INC_TIME", int'(INC_TIME), int'(m_inc_time));
        chk("model_INC_ALM", int'(INC_ALM), int'(m_inc_alm));
        chk("model_ALM_EN", int'(ALM_EN), int'(m_alm_en));
        chk("model_SW_RUN", int'(SW_RUN), int'(m_run));
        chk("model_SW_CLR", int'(SW_CLR), int'(m_clr));
        chk("model_BEEP", int'(BEEP), int'(m_beep_left > 0));
    endtask

    task automatic idle();
        cyc(1, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
    endtask

    task automatic press(input int which);
        cyc(1, which == 0, which == 1, which == 2, 0);
        idle();
    endtask

    typedef struct {
        bit m, f1, f2, am;
        int mode, field, inc_time, inc_alm, alm_en, beep;
    } vec_t;

    vec_t vt[21];

    initial begin
        int cnt, cnt_any;
        bit r, m, f1, f2;

        vt[0]  = '{0,0,0,0, 0,0,0,0,0,0};
        vt[1]  = '{0,1,0,0, 0,0,0,0,1,0};
        vt[2]  = '{0,1,0,0, 0,0,0,0,1,0};
        vt[3]  = '{0,0,1,0, 0,0,0,0,1,0};
        vt[4]  = '{1,0,0,0, 1,0,0,0,1,0};
        vt[5]  = '{0,0,0,0, 1,0,0,0,1,0};
        vt[6]  = '{0,1,0,0, 1,1,0,0,1,0};
        vt[7]  = '{0,0,0,0, 1,1,0,0,1,0};
        vt[8]  = '{0,0,1,0, 1,1,2,0,1,0};
        vt[9]  = '{0,0,1,0, 1,1,0,0,1,0};
        vt[10] = '{1,0,0,0, 2,1,0,0,1,0};
        vt[11] = '{0,0,0,0, 2,1,0,0,1,0};
        vt[12] = '{0,0,1,0, 2,1,0,1,1,0};
        vt[13] = '{0,1,0,0, 2,2,0,0,1,0};
        vt[14] = '{0,0,1,0, 2,2,0,2,1,0};
        vt[15] = '{0,0,0,0, 2,2,0,0,1,0};
        vt[16] = '{0,1,0,0, 2,1,0,0,1,0};
        vt[17] = '{0,0,0,1, 2,1,0,0,1,1};
        vt[18] = '{0,0,0,0, 2,1,0,0,1,1};
        vt[19] = '{0,1,0,0, 2,1,0,0,1,0};
        vt[20] = '{0,0,0,0, 2,1,0,0,1,0};

        do_reset();
        chk("rst_MODE", int'(MODE), 0);
        chk("rst_FIELD", int'(FIELD), 0);
        chk("rst_ALM_EN", int'(ALM_EN), 0);
        chk("rst_BEEP", int'(BEEP), 0);
        chk("rst_SW_RUN", int'(SW_RUN), 0);

        for (int i = 0; i < 21; i++) begin
            cyc(1, vt[i].m, vt[i].f1, vt[i].f2, vt[i].am);
            chk($sformatf("vec%0d_MODE", i), int'(MODE), vt[i].mode);
            chk($sformatf("vec%0d_FIELD", i), int'(FIELD), vt[i].field);
            chk($sformatf("vec%0d_INC_TIME", i), int'(INC_TIME), vt[i].inc_time);
            chk($sformatf("vec%0d_INC_ALM", i), int'(INC_ALM), vt[i].inc_alm);
            chk($sformatf("vec%0d_ALM_EN", i), int'(ALM_EN), vt[i].alm_en);
            chk($sformatf("vec%0d_BEEP", i), int'(BEEP), vt[i].beep);
        end

        // Mode walk from reset.
        do_reset();
        press(0);
        chk("walk1_MODE", int'(MODE), 1);
        chk("walk1_FIELD", int'(FIELD), 0);
        press(0);
        chk("walk2_MODE", int'(MODE), 2);
        chk("walk2_FIELD", int'(FIELD), 1);
        press(0);
        chk("walk3_MODE", int'(MODE), (NMODES == 4) ? 3 : 0);
        press(0);
        chk("walk4_MODE", int'(MODE), (NMODES == 4) ? 0 : 1);

        // SET: field to HOUR, then F2 held 5 cycles gives a single HOUR pulse.
        do_reset();
        press(0);
        press(1);
        press(1);
        chk("set_FIELD", int'(FIELD), 2);
        cnt = 0;
        cnt_any = 0;
        for (int i = 0; i < 6; i++) begin
            cyc(1, 0, 0, i < 5, 0);
            if (INC_TIME == 3'b100) cnt++;
            if (INC_TIME != 3'b000) cnt_any++;
        end
        chk("set_inc_hour_pulses", cnt, 1);
        chk("set_inc_any_pulses", cnt_any, 1);

`ifdef CLOCK_MODE_CTRL_STOPWATCH_EN
        do_reset();
        press(0); press(0); press(0);
        chk("sw_MODE", int'(MODE), 3);
        cyc(1, 0, 0, 1, 0);
        chk("sw_clr_idle", int'(SW_CLR), 1);
        idle();
        chk("sw_clr_width", int'(SW_CLR), 0);
        press(1);
        chk("sw_run_on", int'(SW_RUN), 1);
        cyc(1, 0, 0, 1, 0);
        chk("sw_clr_running", int'(SW_CLR), 0);
        idle();
        press(0);
        chk("sw_run_persist", int'(SW_RUN), 1);
        chk("sw_mode_after", int'(MODE), 0);
`else
        do_reset();
        press(0); press(0);
        chk("nosw_MODE2", int'(MODE), 2);
        press(0);
        chk("nosw_wrap", int'(MODE), 0);
        press(2);
        chk("nosw_SW_RUN", int'(SW_RUN), 0);
        chk("nosw_SW_CLR", int'(SW_CLR), 0);
`endif

        // Alarm beep: full length, a second match mid-beep does not extend it.
        do_reset();
        press(1);
        chk("alm_en_set", int'(ALM_EN), 1);
        cyc(1, 0, 0, 0, 1);
        cnt = int'(BEEP);
        for (int i = 0; i < 11; i++) begin
            cyc(1, 0, 0, 0, i == 3);
            cnt += int'(BEEP);
        end
        chk("beep_len", cnt, BL);
        chk("beep_done", int'(BEEP), 0);
        cyc(1, 0, 0, 0, 1);
        chk("beep2_start", int'(BEEP), 1);
        idle();
        idle();
        cyc(1, 0, 0, 1, 0);
        chk("beep_silenced", int'(BEEP), 0);
        chk("beep_silence_MODE", int'(MODE), 0);
        chk("beep_silence_ALM_EN", int'(ALM_EN), 1);
        idle();

        // SW_MODE and F1 together in SET: mode wins.
        do_reset();
        press(0);
        cyc(1, 1, 1, 0, 0);
        chk("both_MODE", int'(MODE), 2);
        chk("both_FIELD", int'(FIELD), 1);
        chk("both_INC_TIME", int'(INC_TIME), 0);
        chk("both_INC_ALM", int'(INC_ALM), 0);
        idle();

        // Switch held through reset counts once on release.
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        chk("held_rst_MODE", int'(MODE), 1);
        cyc(1, 1, 0, 0, 0);
        chk("held_rst_once", int'(MODE), 1);

        // Reset mid-beep.
        idle();
        press(0); press(0);
        if (NMODES == 4) press(0);
        press(1);
        cyc(1, 0, 0, 0, 1);
        idle();
        cyc(0, 0, 0, 0, 0);
        chk("rst_midbeep_BEEP", int'(BEEP), 0);
        chk("rst_midbeep_ALM_EN", int'(ALM_EN), 0);

        // Randomized traffic against the model.
        m = 0; f1 = 0; f2 = 0;
        for (int i = 0; i < 4000; i++) begin
            r = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 5) == 0) m  = !m;
            if ($urandom_range(0, 4) == 0) f1 = !f1;
            if ($urandom_range(0, 4) == 0) f2 = !f2;
            cyc(r, m, f1, f2, $urandom_range(0, 9) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/clock_mode_ctrl.md
CLOCK_MODE_CTRL -- requirements
Module: clock_mode_ctrl

Interface
REQ-001 Parameter: BEEP_LEN, default 8, alarm beep duration in clock cycles (1..255).
REQ-002 CLK  input  1  system clock; all logic on rising edge.
REQ-003 RST_N  input  1  synchronous, active-low reset.
REQ-004 SW_MODE  input  1  mode switch, level; each 0->1 transition is one press.
REQ-005 SW_F1  input  1  function switch 1, level; each 0->1 transition is one press.
REQ-006 SW_F2  input  1  function switch 2, level; each 0->1 transition is one press.
REQ-007 ALM_MATCH  input  1  one-cycle pulse from the time datapath when the current time equals the alarm time.
REQ-008 MODE  output  2  current mode: 0 CLOCK, 1 SET, 2 ALARM, 3 STOPWATCH.
REQ-009 FIELD  output  2  selected edit field: 0 SEC, 1 MIN, 2 HOUR.
REQ-010 INC_TIME  output  3  one-hot, one-cycle increment pulse to the time counters {HOUR,MIN,SEC}.
REQ-011 INC_ALM  output  2  one-hot, one-cycle increment pulse to the alarm registers {HOUR,MIN}.
REQ-012 ALM_EN  output  1  alarm armed.
REQ-013 SW_RUN  output  1  stopwatch counting enable.
REQ-014 SW_CLR  output  1  one-cycle stopwatch clear pulse.
REQ-015 BEEP  output  1  beeper drive.

Function
REQ-016 Press detection: a press is registered at the edge where the input samples 1 and the previous sample was 0; holding an input high yields exactly one press.
REQ-017 Latency: all effects of a press detected at edge N (mode, field, toggles, pulses) are visible in the cycle after edge N; pulses last exactly one cycle.
REQ-018 A SW_MODE press advances CLOCK->SET->ALARM->STOPWATCH->CLOCK.
REQ-019 Entering SET sets FIELD=SEC; entering ALARM sets FIELD=MIN; in CLOCK and STOPWATCH, FIELD holds its value and is ignored.
REQ-020 CLOCK mode: F1 toggles ALM_EN; F2 has no effect.
REQ-021 SET mode: F1 cycles FIELD SEC->MIN->HOUR->SEC; F2 pulses the INC_TIME bit selected by FIELD.
REQ-022 ALARM mode: F1 cycles FIELD MIN->HOUR->MIN; F2 pulses the INC_ALM bit selected by FIELD.
REQ-023 STOPWATCH mode: F1 toggles SW_RUN; F2 pulses SW_CLR only when SW_RUN=0 and is ignored while running.
REQ-024 SW_RUN and the stopwatch state persist across mode changes; the stopwatch keeps counting outside STOPWATCH mode.
REQ-025 Simultaneous presses in one cycle: SW_MODE wins and F1/F2 are discarded; otherwise F1 wins and F2 is discarded.
REQ-026 ALM_MATCH while ALM_EN=1 and BEEP=0 starts BEEP high for exactly BEEP_LEN cycles; ALM_MATCH while BEEP=1 does not extend it.
REQ-027 Any press while BEEP=1 silences BEEP in the next cycle and is consumed with no other effect.
REQ-028 Clearing ALM_EN while BEEP=1 drops BEEP in the next cycle.

Reset
REQ-029 RST_N=0 at an edge forces MODE=CLOCK, FIELD=SEC, INC_TIME=0, INC_ALM=0, ALM_EN=0, SW_RUN=0, SW_CLR=0, BEEP=0, beep counter=0, and previous-sample registers=0.
REQ-030 After reset is released, a switch already high counts as a press at the first edge where RST_N=1.
REQ-031 Reset asserted mid-beep or mid-press aborts the action with no pulse emitted.

Configuration
REQ-032 Macro CLOCK_MODE_CTRL_STOPWATCH_EN: when defined, the block behaves as described above.
REQ-033 When the macro is not defined, the mode sequence is CLOCK->SET->ALARM->CLOCK, MODE never equals 3, and SW_RUN and SW_CLR are tied to 0.

Structure
REQ-034 The shared package clock_ctrl_pkg holds the mode and field enumerations, their encodings, and the BEEP_LEN default.
REQ-035 One sub-module, sw_edge (register plus rising-edge detect), is instantiated once per switch input.

Verification
REQ-036 Reset, then 4 SW_MODE presses -> MODE steps 1,2,3,0; FIELD=SEC after the first press and MIN after the second.
REQ-037 SET mode, F1 pressed twice, then F2 held high for 5 cycles -> FIELD=HOUR and exactly one INC_TIME=3'b100 pulse.
REQ-038 STOPWATCH mode: F2 -> SW_CLR pulse; F1 -> SW_RUN=1; F2 -> no pulse; SW_MODE press -> SW_RUN stays 1.
REQ-039 CLOCK mode: F1 sets ALM_EN=1; ALM_MATCH pulse -> BEEP high for 8 cycles; repeat, with F2 pressed in beep cycle 3 -> BEEP low in the next cycle and MODE unchanged.
REQ-040 SW_MODE and F1 pressed in the same cycle in SET mode -> MODE=ALARM, FIELD=MIN, no INC pulse.
REQ-041 Build without the macro: starting from MODE=2, a SW_MODE press -> MODE=0; SW_RUN and SW_CLR stay 0 throughout.
